uart_tx_fifo: RTL

//   Parametrised UART transmitter with an integrated synchronous FIFO, for the APB UART TX path.

---
 rtl/uart_tx_fifo.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO; frames (start, data LSB-first,
// optional parity, 1-2 stop bits) are sent back-to-back while words remain queued.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_BITS-1:0]       data_i,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic                       tx,
    output logic                       tx_busy,
    output logic                       tx_done,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be in 5..8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Parity of a whole data word: even sends the XOR, odd sends its complement.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    state_t               state, state_n;
    logic [BW-1:0]        baud_cnt, baud_n;
    logic [2:0]           bit_cnt, bit_n;
    logic                 tx_r, tx_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;

    logic push, pop, done, baud_last, fifo_nonempty;

    assign head          = mem[rd_ptr];
    assign fifo_nonempty = (count != '0);
    assign baud_last     = (baud_cnt == BAUD_LAST);
    assign ready_in      = !rst && (count != FULL_CNT);
    assign push          = valid_in && ready_in;

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        tx_n    = tx_r;
        shift_n = shift_reg;
        pop     = 1'b0;
        done    = 1'b0;
        baud_n  = (state == S_IDLE || baud_last) ? '0 : baud_cnt + BW'(1);

        case (state)
            S_IDLE: begin
                tx_n  = 1'b1;
                bit_n = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    tx_n    = shift_reg[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shift_n = shift_reg >> 1;
                        tx_n    = shift_reg[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                tx_n = 1'b1;
                if (baud_last) begin
                    if (bit_cnt == STOP_LAST) begin
                        done  = 1'b1;
                        bit_n = '0;
                        // Chain straight into the next start bit when more words wait.
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            tx_n    = 1'b0;
                            state_n = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_r     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            tx_r     <= tx_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage and shift path carry no reset; control state alone decides validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
        if (pop) begin
            shift_reg <= head;
            par_bit   <= parity_of(head);
        end else begin
            shift_reg <= shift_n;
        end
    end

    assign tx         = tx_r;
    assign tx_busy    = (state != S_IDLE);
    assign tx_done    = done && !rst;
    assign fifo_count = count;

endmodule
